// File: rtl/div_pkg.sv
// Shared types and constants for the sequential signed divider.
package div_pkg;

    localparam int unsigned DEF_WIDTH = 32;
    localparam int unsigned DEF_CNT_W = 6;

    // Quotient reported for a divide by zero (all ones)
    localparam logic [DEF_WIDTH-1:0] DIV0_QUOTIENT = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration on unsigned magnitudes.
module div_step #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] quo,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_next,
    output logic [WIDTH-1:0] quo_next
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    // Shift in the next dividend bit, trial-subtract, restore on borrow
    always_comb begin
        shifted  = {rem, quo[WIDTH-1]};
        diff     = shifted - {1'b0, divisor};
        rem_next = shifted[WIDTH-1:0];
        quo_next = {quo[WIDTH-2:0], 1'b0};
        if (!diff[WIDTH]) begin
            rem_next = diff[WIDTH-1:0];
            quo_next = {quo[WIDTH-2:0], 1'b1};
        end
    end

endmodule

// File: rtl/div.sv
// Sequential signed divider: one quotient bit per clock, lo = quotient, hi = remainder.
module div
    import div_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             div_zero
);

    state_t           state;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] divisor;
    logic [CNT_W-1:0] cnt;
    logic             sign_q;
    logic             sign_r;

    logic [WIDTH-1:0] abs_a_c;
    logic [WIDTH-1:0] abs_b_c;
    logic [WIDTH-1:0] rem_next_c;
    logic [WIDTH-1:0] quo_next_c;

    // Operand magnitudes; the most negative value maps onto itself as unsigned
    assign abs_a_c = a[WIDTH-1] ? WIDTH'(-a) : a;
    assign abs_b_c = b[WIDTH-1] ? WIDTH'(-b) : b;

    div_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .rem      (rem),
        .quo      (quo),
        .divisor  (divisor),
        .rem_next (rem_next_c),
        .quo_next (quo_next_c)
    );

    // Control FSM, iteration datapath and sign fix-up
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            rem      <= '0;
            quo      <= '0;
            divisor  <= '0;
            cnt      <= '0;
            sign_q   <= 1'b0;
            sign_r   <= 1'b0;
            hi       <= '0;
            lo       <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    state <= IDLE;
                    if (start) begin
                        sign_q  <= a[WIDTH-1] ^ b[WIDTH-1];
                        sign_r  <= a[WIDTH-1];
                        quo     <= abs_a_c;
                        divisor <= abs_b_c;
                        rem     <= '0;
                        cnt     <= CNT_W'(WIDTH);
                        if (b == '0) begin
                            state    <= DONE;
                            done     <= 1'b1;
                            div_zero <= 1'b1;
                            hi       <= a;
                            // Sign-extending all ones keeps it all ones at any width
                            lo       <= WIDTH'($signed(DIV0_QUOTIENT));
                        end else begin
                            state    <= CALC;
                            busy     <= 1'b1;
                            div_zero <= 1'b0;
                        end
                    end
                end
                CALC: begin
                    rem <= rem_next_c;
                    quo <= quo_next_c;
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    lo    <= sign_q ? WIDTH'(-quo) : quo;
                    hi    <= sign_r ? WIDTH'(-rem) : rem;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= DONE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
